cfg_chain_loader: RTL and testbench

Synthesizable configuration-bitstream loader for the fabric's serial configuration chains (connection boxes, switch boxes, logic blocks, I/O blocks). It accepts a word stream from the host or a boot memory, parses one header per chain, and shifts each chain's payload out LSB-first with a per-chain program enable. A latch gap separates consecutive tiles. It sits between the configuration port and the fabric's `bit_in_*` / `*_prgm_b` inputs, and replaces per-chain shift counters with one parametrised engine.

---
 rtl/cfg_loader_pkg.sv | 26 ++
 rtl/cfg_crc16_serial.sv | 29 ++
 rtl/cfg_chain_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared state encoding, header layout and CRC constants for cfg_chain_loader
// Optional CRC trailer check is enabled by defining CFG_CHAIN_LOADER_CRC_EN.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4,
`ifdef CFG_CHAIN_LOADER_CRC_EN
    ST_CHK   = 3'd5,
`endif
    ST_DONE  = 3'd6
  } state_t;

  // Header word layout: bits_per_tile in the low field, tile_count above it.
  localparam int HDR_BITS_LSB  = 0;
  localparam int HDR_TILES_LSB = 16;
  localparam int HDR_FIELD_W   = 16;

  // CRC-16-CCITT, computed MSB-first over the shifted bit order.
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

endpackage

// File: rtl/cfg_crc16_serial.sv
// rtl/cfg_crc16_serial.sv - bit-serial CRC-16 over the configuration bit stream
// Only instantiated when CFG_CHAIN_LOADER_CRC_EN is defined.
module cfg_crc16_serial
  import cfg_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ bit_in;

  // Shift one bit into the CRC per enabled cycle; clear reloads the seed for a new chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_SEED;
    end else if (clear) begin
      crc <= CRC_SEED;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - header-driven serial loader for the fabric configuration chains
// Define CFG_CHAIN_LOADER_CRC_EN to add a per-chain CRC trailer word and check.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WORD_W   = 32,
  parameter int TILE_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NUM_CH-1:0] cfg_bit,
  output logic [NUM_CH-1:0] cfg_en,
  output logic [NUM_CH-1:0] cfg_latch,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WL_W  = $clog2(WORD_W + 1);
  localparam int GAP_W = (TILE_GAP > 1) ? $clog2(TILE_GAP) : 1;

  state_t                  state;
  logic [CH_W-1:0]         ch;
  logic [15:0]             bits_per_tile;
  logic [15:0]             tiles_left;
  logic [15:0]             bit_cnt;
  logic [WORD_W-1:0]       sreg;
  logic [WL_W-1:0]         word_left;
  logic [GAP_W-1:0]        gap_cnt;

  logic                    xfer;
  logic [15:0]             hdr_bits;
  logic [15:0]             hdr_tiles;
  logic [NUM_CH-1:0]       ch_mask;
  logic                    last_ch;
  logic                    tile_end;
  logic                    word_last;
  logic                    gap_end;
  logic                    advance;

  assign xfer      = in_valid && in_ready;
  assign hdr_bits  = in_data[HDR_BITS_LSB +: HDR_FIELD_W];
  assign hdr_tiles = in_data[HDR_TILES_LSB +: HDR_FIELD_W];
  assign ch_mask   = NUM_CH'(1) << ch;
  assign last_ch   = (ch == CH_W'(NUM_CH - 1));
  assign tile_end  = (bit_cnt == bits_per_tile - 16'd1);
  assign word_last = (word_left == WL_W'(1));
  assign gap_end   = (gap_cnt == GAP_W'(TILE_GAP - 1));

`ifdef CFG_CHAIN_LOADER_CRC_EN
  logic        crc_clear;
  logic        crc_en;
  logic [15:0] crc_val;

  assign crc_clear = (state == ST_HDR) && xfer;
  assign crc_en    = (state == ST_SHIFT);

  cfg_crc16_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .en     (crc_en),
    .bit_in (sreg[0]),
    .crc    (crc_val)
  );
`endif

  // Detect the end of a chain so the channel index moves on (or the load finishes).
  always_comb begin
    advance = 1'b0;
`ifdef CFG_CHAIN_LOADER_CRC_EN
    if (state == ST_CHK && xfer && in_data[HDR_FIELD_W-1:0] == crc_val) begin
      advance = 1'b1;
    end
`else
    if (state == ST_HDR && xfer && hdr_tiles == 16'd0) begin
      advance = 1'b1;
    end
    if (state == ST_GAP && gap_end && tiles_left == 16'd0) begin
      advance = 1'b1;
    end
`endif
  end

  // Main sequencer; outputs are registered with the value they take in the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ch            <= '0;
      bits_per_tile <= '0;
      tiles_left    <= '0;
      bit_cnt       <= '0;
      sreg          <= '0;
      word_left     <= '0;
      gap_cnt       <= '0;
      in_ready      <= 1'b0;
      cfg_bit       <= '0;
      cfg_en        <= '0;
      cfg_latch     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done      <= 1'b0;
      cfg_latch <= '0;
      cfg_en    <= '0;
      cfg_bit   <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            ch       <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            bits_per_tile <= hdr_bits;
            tiles_left    <= hdr_tiles;
            bit_cnt       <= '0;
            word_left     <= '0;
            if (hdr_tiles == 16'd0) begin
`ifdef CFG_CHAIN_LOADER_CRC_EN
              state <= ST_CHK;
`endif
            end else if (hdr_bits == 16'd0) begin
              err      <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              state    <= ST_DONE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            sreg      <= in_data;
            word_left <= WL_W'(WORD_W);
            in_ready  <= 1'b0;
            cfg_en    <= ch_mask;
            cfg_bit   <= in_data[0] ? ch_mask : '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg      <= sreg >> 1;
          word_left <= word_left - WL_W'(1);
          if (tile_end) begin
            bit_cnt    <= '0;
            tiles_left <= tiles_left - 16'd1;
            gap_cnt    <= '0;
            cfg_latch  <= ch_mask;
            state      <= ST_GAP;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
            if (word_last) begin
              in_ready <= 1'b1;
              state    <= ST_LOAD;
            end else begin
              cfg_en  <= ch_mask;
              cfg_bit <= sreg[1] ? ch_mask : '0;
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            if (tiles_left != 16'd0) begin
              if (word_left == '0) begin
                in_ready <= 1'b1;
                state    <= ST_LOAD;
              end else begin
                cfg_en  <= ch_mask;
                cfg_bit <= sreg[0] ? ch_mask : '0;
                state   <= ST_SHIFT;
              end
            end
`ifdef CFG_CHAIN_LOADER_CRC_EN
            else begin
              in_ready <= 1'b1;
              state    <= ST_CHK;
            end
`endif
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`ifdef CFG_CHAIN_LOADER_CRC_EN
        ST_CHK: begin
          if (xfer && in_data[HDR_FIELD_W-1:0] != crc_val) begin
            err      <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            state    <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (advance) begin
        if (last_ch) begin
          done     <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= ST_DONE;
        end else begin
          ch       <= ch + CH_W'(1);
          in_ready <= 1'b1;
          state    <= ST_HDR;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - directed self-checking bench for cfg_chain_loader
// Covers the CRC trailer path too when CFG_CHAIN_LOADER_CRC_EN is defined.
module tb_cfg_chain_loader;
  import cfg_loader_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cfg_bit;
  logic [3:0]  cfg_en;
  logic [3:0]  cfg_latch;
  logic        busy;
  logic        done;
  logic        err;

  cfg_chain_loader #(.NUM_CH(4), .WORD_W(32), .TILE_GAP(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_bit   (cfg_bit),
    .cfg_en    (cfg_en),
    .cfg_latch (cfg_latch),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] pay [3];
  logic [31:0] words [$];

  // run parameters
  int stall_idx, stall_n, busy_start_at, reset_at;
  // run results
  logic bits_q [$];
  int   latch_q [$];
  int   en_total, other_en, stray_bit, latch_bad, gap32, gap48;
  int   done_cnt, xfer_cnt;
  logic err_after_start;
  bit   timed_out, aborted;

  function automatic logic exp_bit(int i);
    logic [31:0] w;
    w = pay[i / 32];
    return w[i % 32];
  endfunction

  function automatic logic [15:0] crc_bits(int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ exp_bit(i);
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic make_basic(input logic [15:0] trailer_flip);
    words.delete();
    words.push_back(32'h0002_0030);
    for (int k = 0; k < 3; k++) words.push_back(pay[k]);
`ifdef CFG_CHAIN_LOADER_CRC_EN
    words.push_back({16'h0000, crc_bits(96) ^ trailer_flip});
`endif
    for (int k = 1; k < 4; k++) begin
      words.push_back(32'h0000_0010);
`ifdef CFG_CHAIN_LOADER_CRC_EN
      words.push_back(32'h0000_FFFF);
`endif
    end
  endtask

  task automatic clear_params();
    stall_idx = -1; stall_n = 0; busy_start_at = 0; reset_at = 0;
  endtask

  function automatic int bit_errors();
    int n;
    n = 0;
    for (int i = 0; i < bits_q.size(); i++)
      if (bits_q[i] !== exp_bit(i)) n++;
    return n;
  endfunction

  task automatic run_load();
    int   idx, stall_left, idle, post;
    bit   prev_xfer, done_seen, bs_fired;
    bits_q.delete(); latch_q.delete();
    en_total = 0; other_en = 0; stray_bit = 0; latch_bad = 0; gap32 = -1; gap48 = -1;
    done_cnt = 0; xfer_cnt = 0; err_after_start = 1'bx; timed_out = 0; aborted = 0;
    idx = 0; stall_left = stall_n; idle = 0; post = 0;
    prev_xfer = 0; done_seen = 0; bs_fired = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_xfer) begin idx++; xfer_cnt++; end
      if (cyc == 1) err_after_start = err;
      if (cfg_en != 4'b0000) begin
        if (cfg_en != 4'b0001) other_en++;
        bits_q.push_back(cfg_bit[0]);
        en_total++;
        if (en_total == 33) gap32 = idle;
        if (en_total == 49) gap48 = idle;
        idle = 0;
      end else begin
        idle++;
        if (cfg_bit != 4'b0000) stray_bit++;
      end
      if (cfg_latch != 4'b0000) begin
        latch_q.push_back(en_total);
        if (cfg_latch != 4'b0001 || cfg_en != 4'b0000) latch_bad++;
      end
      if (done) done_cnt++;
      if (reset_at > 0 && en_total == reset_at) begin
        reset = 1'b1; in_valid = 1'b0; start = 1'b0; aborted = 1;
        return;
      end
      start = (cyc == 0);
      if (busy_start_at > 0 && !bs_fired && en_total == busy_start_at && cfg_en != 4'b0000) begin
        start = 1'b1; bs_fired = 1;
      end
      if (stall_left > 0 && idx == stall_idx && in_ready) begin
        in_valid = 1'b0; stall_left--;
      end else if (idx < words.size()) begin
        in_valid = 1'b1; in_data = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      prev_xfer = in_valid && in_ready;
      if (done_seen) begin
        post++;
        if (post == 3) break;
      end
      if (done) done_seen = 1;
    end
    start = 1'b0; in_valid = 1'b0;
    if (!done_seen) timed_out = 1;
  endtask

  task automatic check_full_load(input string tag);
    compared++;
    if (timed_out !== 1'b0) begin mismatched++; $display("FAIL %s_timeout: got %0d expected 0", tag, timed_out); end
    compared++;
    if (en_total !== 96) begin mismatched++; $display("FAIL %s_en_cycles: got %0d expected 96", tag, en_total); end
    compared++;
    if (bit_errors() !== 0) begin mismatched++; $display("FAIL %s_bit_seq: got %0d wrong bits expected 0", tag, bit_errors()); end
    compared++;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL %s_err: got %0b expected 0", tag, err); end
    compared++;
    if (latch_q.size() !== 2) begin mismatched++; $display("FAIL %s_latch_count: got %0d expected 2", tag, latch_q.size()); end
    else begin
      compared++;
      if (latch_q[0] !== 48 || latch_q[1] !== 96) begin
        mismatched++; $display("FAIL %s_latch_pos: got %0d,%0d expected 48,96", tag, latch_q[0], latch_q[1]);
      end
    end
    compared++;
    if (gap48 !== 1) begin mismatched++; $display("FAIL %s_tile_gap: got %0d expected 1", tag, gap48); end
    compared++;
    if (other_en + stray_bit + latch_bad !== 0) begin
      mismatched++; $display("FAIL %s_chain_select: got %0d/%0d/%0d expected 0/0/0", tag, other_en, stray_bit, latch_bad);
    end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL %s_busy_end: got %0b expected 0", tag, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({in_ready, cfg_bit, cfg_en, cfg_latch, busy, done, err} !== 15'd0) begin
      mismatched++; $display("FAIL reset_outputs: got %h expected 0", {in_ready, cfg_bit, cfg_en, cfg_latch, busy, done, err});
    end
    compared++;
    if (dut.state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_params(); make_basic(16'h0000); run_load();
    check_full_load("basic");
    compared++;
    if (gap32 !== 1) begin mismatched++; $display("FAIL basic_load_gap: got %0d expected 1", gap32); end
  endtask

  task automatic test_valid_stall();
    clear_params(); stall_idx = 2; stall_n = 5; make_basic(16'h0000); run_load();
    check_full_load("stall");
    compared++;
    if (gap32 !== 6) begin mismatched++; $display("FAIL stall_load_gap: got %0d expected 6", gap32); end
  endtask

  task automatic test_bad_header();
    clear_params();
    words.delete(); words.push_back(32'h0003_0000);
    run_load();
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL badhdr_err: got %0b expected 1", err); end
    compared++;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL badhdr_done: got %0d expected 1", done_cnt); end
    compared++;
    if (en_total !== 0) begin mismatched++; $display("FAIL badhdr_en: got %0d expected 0", en_total); end
  endtask

  task automatic test_busy_start();
    clear_params(); busy_start_at = 10; make_basic(16'h0000); run_load();
    compared++;
    if (err_after_start !== 1'b0) begin mismatched++; $display("FAIL start_clears_err: got %0b expected 0", err_after_start); end
    check_full_load("busystart");
  endtask

  task automatic test_reset_mid_load();
    clear_params(); reset_at = 20; make_basic(16'h0000); run_load();
    #1;
    compared++;
    if (aborted !== 1'b1) begin mismatched++; $display("FAIL midreset_reached: got %0b expected 1", aborted); end
    compared++;
    if ({in_ready, cfg_bit, cfg_en, cfg_latch, busy, done, err} !== 15'd0) begin
      mismatched++; $display("FAIL midreset_outputs: got %h expected 0", {in_ready, cfg_bit, cfg_en, cfg_latch, busy, done, err});
    end
    compared++;
    if (dut.state !== ST_IDLE) begin mismatched++; $display("FAIL midreset_state: got %0d expected %0d", dut.state, ST_IDLE); end
    compared++;
    if (latch_q.size() !== 0) begin mismatched++; $display("FAIL midreset_latch: got %0d expected 0", latch_q.size()); end
    @(negedge clk);
    reset = 1'b0;
    clear_params(); make_basic(16'h0000); run_load();
    check_full_load("reload");
  endtask

`ifdef CFG_CHAIN_LOADER_CRC_EN
  task automatic test_crc_bad();
    clear_params(); make_basic(16'h0004); run_load();
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL crc_bad_err: got %0b expected 1", err); end
    compared++;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL crc_bad_done: got %0d expected 1", done_cnt); end
    compared++;
    if (xfer_cnt !== 5) begin mismatched++; $display("FAIL crc_bad_words: got %0d expected 5", xfer_cnt); end
  endtask
`endif

  initial begin
    pay[0] = 32'hA5C3_0F96;
    pay[1] = 32'h1234_5678;
    pay[2] = 32'hDEAD_BEEF;
    test_reset();
    test_basic();
    test_valid_stall();
    test_bad_header();
    test_busy_start();
    test_reset_mid_load();
`ifdef CFG_CHAIN_LOADER_CRC_EN
    test_crc_bad();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
